// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low hex glyphs, blank glyph and the
// scan receiver state encoding.
package seg7_pkg;

    // Active-low g..a patterns, index = hex value (index 0 in the low slice)
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational reverse decoder: active-low segment pattern back to a hex
// nibble, flagging recognized glyphs and the blank glyph separately.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_hit,
    output logic       o_blank,
    output logic [3:0] o_value
);

    always_comb begin
        o_hit   = 1'b0;
        o_value = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (i_pattern == SEG_PATTERNS[k]) begin
                o_hit   = 1'b1;
                o_value = 4'(k);
            end
        end
        o_blank = (i_pattern == BLANK);
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive side of a multiplexed common-anode 7-segment bus: synchronizes the
// scanned cs/seg pair, waits for each digit window to settle and decodes it.
module seg_scan_rx
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200000,
    parameter int NDIG    = 4
) (
    input  logic                cp,
    input  logic                cr,
    input  logic [NDIG-1:0]     cs,
    input  logic [7:0]          seg,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dig_vld,
    output logic [NDIG-1:0]     dp,
    output logic                upd,
    output logic                err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [NDIG-1:0]   r_cs_s1, r_cs_s2, r_lat_cs;
    logic [7:0]        r_seg_s1, r_seg_s2, r_lat_seg;
    scan_state_t       r_state, w_state_next;
    logic [CW-1:0]     r_count;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_vld, r_dp;
    logic              r_upd, r_err;
    logic [6*NDIG-1:0] r_prev;
    logic [TW-1:0]     r_tmo [NDIG];

    logic              w_onehot, w_same, w_latch, w_count_inc, w_capture;
    logic              w_hit, w_blank;
    logic [3:0]        w_value;
    logic [NDIG-1:0]   w_cap_mask;
    logic [6*NDIG-1:0] w_outs;

    always_ff @(posedge cp) begin
        if (cr) begin
            r_cs_s1  <= '1;
            r_cs_s2  <= '1;
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
        end else begin
            r_cs_s1  <= cs;
            r_cs_s2  <= r_cs_s1;
            r_seg_s1 <= seg;
            r_seg_s2 <= r_seg_s1;
        end
    end

    assign w_onehot = ($countones(~r_cs_s2) == 1);
    assign w_same   = (r_cs_s2 == r_lat_cs) && (r_seg_s2 == r_lat_seg);

    // CAPTURE re-checks the pair so a window of exactly SETTLE samples is still dropped
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_count_inc  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_latch      = 1'b1;
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_same) begin
                    w_count_inc = 1'b1;
                    if (r_count == CNT_LAST) w_state_next = S_CAPTURE;
                end else if (w_onehot) begin
                    w_latch = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CAPTURE: begin
                w_capture    = w_same;
                w_state_next = w_same ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!w_same) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge cp) begin
        if (cr) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_lat_cs  <= '1;
            r_lat_seg <= '1;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_lat_cs  <= r_cs_s2;
                r_lat_seg <= r_seg_s2;
                r_count   <= CW'(1);
            end else if (w_count_inc) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    seg7_pattern_dec u_dec (
        .i_pattern (r_lat_seg[6:0]),
        .o_hit     (w_hit),
        .o_blank   (w_blank),
        .o_value   (w_value)
    );

    assign w_cap_mask = w_capture ? ~r_lat_cs : '0;

    always_ff @(posedge cp) begin
        if (cr) begin
            r_digits <= '0;
            r_vld    <= '0;
            r_dp     <= '0;
            r_err    <= 1'b0;
            for (int k = 0; k < NDIG; k++) r_tmo[k] <= '0;
        end else begin
            for (int k = 0; k < NDIG; k++) begin
                if (w_cap_mask[k]) begin
                    r_tmo[k] <= '0;
                    r_dp[k]  <= ~r_lat_seg[7];
                    r_vld[k] <= w_hit;
                    if (w_hit) r_digits[4*k +: 4] <= w_value;
                end else if (r_tmo[k] != TMO_MAX) begin
                    r_tmo[k] <= r_tmo[k] + TW'(1);
                    if (r_tmo[k] == TMO_LAST) r_vld[k] <= 1'b0;
                end
            end
            if (w_capture && !w_hit && !w_blank) r_err <= 1'b1;
        end
    end

    // Change detect against last cycle's outputs, so identical re-captures stay silent
    assign w_outs = {r_digits, r_vld, r_dp};

    always_ff @(posedge cp) begin
        if (cr) begin
            r_prev <= '0;
            r_upd  <= 1'b0;
        end else begin
            r_prev <= w_outs;
            r_upd  <= (w_outs != r_prev);
        end
    end

    assign digits  = r_digits;
    assign dig_vld = r_vld;
    assign dp      = r_dp;
    assign upd     = r_upd;
    assign err     = r_err;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Self-checking bench for seg_scan_rx: directed timing sequences, a decode
// vector table and randomized digit windows against a per-window model.
module tb_seg_scan_rx;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1000;

    logic        cp = 1'b0;
    logic        cr;
    logic [3:0]  cs;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dig_vld;
    logic [3:0]  dp;
    logic        upd;
    logic        err;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [6:0] hexPattern [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [3:0] cs;
        logic [7:0] seg;
        logic [3:0] expDigit;
        logic       expVld;
        logic       expDp;
        logic       expErr;
    } vec_t;

    vec_t vecs [20];

    always #5 cp = ~cp;

    seg_scan_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .NDIG(4)) dut (
        .cp      (cp),
        .cr      (cr),
        .cs      (cs),
        .seg     (seg),
        .digits  (digits),
        .dig_vld (dig_vld),
        .dp      (dp),
        .upd     (upd),
        .err     (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic [7:0] s);
        cs  = c;
        seg = s;
    endtask

    // Advance n clocks, sampling on the falling edge and counting upd pulses
    task automatic runCycles(input int n, output int updCount);
        updCount = 0;
        repeat (n) begin
            @(posedge cp);
            @(negedge cp);
            if (upd === 1'b1) updCount++;
        end
    endtask

    task automatic doReset();
        cr = 1'b1;
        applyStimulus(4'hF, 8'hFF);
        repeat (2) @(posedge cp);
        @(negedge cp);
        cr = 1'b0;
    endtask

    function automatic int digitIndex(input logic [3:0] c);
        int idx = -1;
        if ($countones(~c) == 1)
            for (int k = 0; k < 4; k++) if (!c[k]) idx = k;
        return idx;
    endfunction

    initial begin
        int          n;
        int          idx;
        int          updTotal;
        logic [3:0]  mDigit [4];
        logic [3:0]  mVld, mDp;
        logic        mErr;
        logic [15:0] mPacked, oldPacked;
        logic [3:0]  oldVld, oldDp;
        logic [3:0]  rCs;
        logic [7:0]  rSeg;
        int          len, pick, hexVal;
        logic        hit;

        vecs[0]  = '{4'hE, 8'hC0, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'hD, 8'h79, 4'h1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{4'hB, 8'hA4, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'h7, 8'h30, 4'h3, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{4'hE, 8'h99, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'hD, 8'h12, 4'h5, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'hB, 8'h82, 4'h6, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'h7, 8'h78, 4'h7, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{4'hE, 8'h80, 4'h8, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'hD, 8'h10, 4'h9, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{4'hB, 8'h88, 4'hA, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'h7, 8'h03, 4'hB, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{4'hE, 8'hC6, 4'hC, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'hD, 8'h21, 4'hD, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{4'hB, 8'h86, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{4'h7, 8'h0E, 4'hF, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{4'hE, 8'hFF, 4'hC, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{4'hD, 8'h7F, 4'hD, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{4'hB, 8'h8F, 4'hE, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{4'hE, 8'hC0, 4'h0, 1'b1, 1'b0, 1'b1};

        // Reset state and a long idle bus
        doReset();
        checkOutput("reset digits", 32'(digits), 32'h0);
        checkOutput("reset dig_vld", 32'(dig_vld), 32'h0);
        checkOutput("reset dp", 32'(dp), 32'h0);
        checkOutput("reset upd", 32'(upd), 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);
        runCycles(1000, n);
        checkOutput("idle upd count", 32'(n), 32'h0);
        checkOutput("idle digits", 32'(digits), 32'h0);
        checkOutput("idle dig_vld", 32'(dig_vld), 32'h0);
        checkOutput("idle err", 32'(err), 32'h0);

        // Capture latency is SETTLE+3 clocks after the pin change
        applyStimulus(4'hE, 8'h92);
        for (int k = 1; k <= 20; k++) begin
            @(posedge cp);
            @(negedge cp);
            checkOutput($sformatf("latency digit c%0d", k), 32'(digits[3:0]), (k >= SETTLE + 3) ? 32'h5 : 32'h0);
            checkOutput($sformatf("latency vld c%0d", k), 32'(dig_vld), (k >= SETTLE + 3) ? 32'h1 : 32'h0);
            checkOutput($sformatf("latency upd c%0d", k), 32'(upd), (k == SETTLE + 4) ? 32'h1 : 32'h0);
        end

        // Short select windows (3 and SETTLE samples) are rejected
        applyStimulus(4'hF, 8'hFF);
        runCycles(10, n);
        for (int w = 3; w <= SETTLE; w++) begin
            applyStimulus(4'hB, 8'h80);
            runCycles(w, n);
            updTotal = n;
            applyStimulus(4'hF, 8'hFF);
            runCycles(20, n);
            updTotal += n;
            checkOutput($sformatf("glitch%0d digits", w), 32'(digits), 32'h0005);
            checkOutput($sformatf("glitch%0d dig_vld", w), 32'(dig_vld), 32'h1);
            checkOutput($sformatf("glitch%0d upd count", w), 32'(updTotal), 32'h0);
        end

        // Blank vs. unrecognized patterns, sticky err
        applyStimulus(4'h7, 8'hFF);
        runCycles(15, n);
        checkOutput("blank vld3", 32'(dig_vld[3]), 32'h0);
        checkOutput("blank err", 32'(err), 32'h0);
        applyStimulus(4'h7, 8'hAA);
        runCycles(15, n);
        checkOutput("bad pattern err", 32'(err), 32'h1);
        checkOutput("bad pattern vld3", 32'(dig_vld[3]), 32'h0);
        applyStimulus(4'hE, 8'hF9);
        runCycles(15, n);
        checkOutput("err sticky", 32'(err), 32'h1);
        checkOutput("after err digits", 32'(digits), 32'h0001);

        // Decode vector table
        doReset();
        foreach (vecs[v]) begin
            applyStimulus(vecs[v].cs, vecs[v].seg);
            runCycles(12, n);
            idx = digitIndex(vecs[v].cs);
            checkOutput($sformatf("vec%0d digit", v), 32'(digits[4*idx +: 4]), 32'(vecs[v].expDigit));
            checkOutput($sformatf("vec%0d vld", v), 32'(dig_vld[idx]), 32'(vecs[v].expVld));
            checkOutput($sformatf("vec%0d dp", v), 32'(dp[idx]), 32'(vecs[v].expDp));
            checkOutput($sformatf("vec%0d err", v), 32'(err), 32'(vecs[v].expErr));
        end

        // Reset in the middle of a settle window
        applyStimulus(4'hF, 8'hFF);
        runCycles(10, n);
        applyStimulus(4'hE, 8'hC0);
        runCycles(4, n);
        cr = 1'b1;
        @(posedge cp);
        @(negedge cp);
        checkOutput("midreset digits", 32'(digits), 32'h0);
        checkOutput("midreset dig_vld", 32'(dig_vld), 32'h0);
        checkOutput("midreset dp", 32'(dp), 32'h0);
        checkOutput("midreset upd", 32'(upd), 32'h0);
        checkOutput("midreset err", 32'(err), 32'h0);
        cr = 1'b0;
        runCycles(SETTLE + 2, n);
        checkOutput("post reset early vld", 32'(dig_vld), 32'h0);
        runCycles(1, n);
        checkOutput("post reset digit0", 32'(digits[3:0]), 32'h0);
        checkOutput("post reset vld", 32'(dig_vld), 32'h1);

        // Randomized digit windows against the per-window model
        doReset();
        for (int k = 0; k < 4; k++) mDigit[k] = 4'h0;
        mVld = '0;
        mDp  = '0;
        mErr = 1'b0;
        for (int w = 0; w < 25; w++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      rCs = 4'hF;
            else if (pick == 1) rCs = 4'hC;
            else                rCs = ~(4'b0001 << $urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            if (pick <= 6) begin
                hexVal = $urandom_range(0, 15);
                rSeg   = {1'($urandom_range(0, 1)), hexPattern[hexVal]};
            end else if (pick == 7) begin
                rSeg = {1'($urandom_range(0, 1)), 7'h7F};
            end else begin
                rSeg = 8'($urandom_range(0, 255));
            end
            len = $urandom_range(12, 30);

            for (int k = 0; k < 4; k++) oldPacked[4*k +: 4] = mDigit[k];
            oldVld = mVld;
            oldDp  = mDp;
            idx = digitIndex(rCs);
            if (idx >= 0) begin
                hit = 1'b0;
                for (int h = 0; h < 16; h++) begin
                    if (rSeg[6:0] == hexPattern[h]) begin
                        hit         = 1'b1;
                        mDigit[idx] = 4'(h);
                    end
                end
                mVld[idx] = hit;
                mDp[idx]  = ~rSeg[7];
                if (!hit && rSeg[6:0] != 7'h7F) mErr = 1'b1;
            end
            for (int k = 0; k < 4; k++) mPacked[4*k +: 4] = mDigit[k];

            applyStimulus(rCs, rSeg);
            runCycles(len, n);
            checkOutput($sformatf("rand%0d digits", w), 32'(digits), 32'(mPacked));
            checkOutput($sformatf("rand%0d dig_vld", w), 32'(dig_vld), 32'(mVld));
            checkOutput($sformatf("rand%0d dp", w), 32'(dp), 32'(mDp));
            checkOutput($sformatf("rand%0d err", w), 32'(err), 32'(mErr));
            checkOutput($sformatf("rand%0d upd count", w), 32'(n),
                        ({mPacked, mVld, mDp} != {oldPacked, oldVld, oldDp}) ? 32'h1 : 32'h0);
        end

        // Alternating scan then bus loss: valids time out one by one
        doReset();
        for (int r = 0; r < 2; r++) begin
            applyStimulus(4'hE, 8'hF9);
            runCycles(50, n);
            applyStimulus(4'hD, 8'hA4);
            runCycles(50, n);
        end
        checkOutput("scan digits", 32'(digits), 32'h0021);
        checkOutput("scan dig_vld", 32'(dig_vld), 32'h3);
        applyStimulus(4'hF, 8'hFF);
        runCycles(850, n);
        updTotal = n;
        checkOutput("before timeout dig_vld", 32'(dig_vld), 32'h3);
        runCycles(TIMEOUT + 5 - 850, n);
        updTotal += n;
        checkOutput("timeout dig_vld", 32'(dig_vld), 32'h0);
        checkOutput("timeout digits kept", 32'(digits), 32'h0021);
        checkOutput("timeout upd count", 32'(updTotal), 32'h2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
